// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write bus and load status of the program loader.
// The master modport is the loader side; the slave side is the byte source / memory / core.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_hold;
    logic                  load_done;
    logic                  load_error;

    modport master (
        input  rx_valid, rx_byte,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output core_hold, load_done, load_error
    );

    modport slave (
        output rx_valid, rx_byte,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  core_hold, load_done, load_error
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes them to instruction memory
// and releases the core only after a frame with a matching XOR checksum has been written.
module program_loader #(
    parameter int         ADDR_WIDTH     = 10,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input logic              clock,
    input logic              reset,
    program_loader_if.master bus
);
    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          IW       = ADDR_WIDTH + 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR} state_t;

    state_t state, state_nxt;

    logic                  hs, is_sync, timed, expired, last_lane, last_word;
    logic                  rdy, hold, done, err;
    logic [31:0]           len_new;
    logic [15:0]           len_q;
    logic [7:0]            chk_q;
    logic [IW-1:0]         idx_q;
    logic [1:0]            lane_q;
    logic [23:0]           shift_q;
    logic [TW-1:0]         timer_q;
    logic                  imem_we_p1;
    logic [ADDR_WIDTH-1:0] imem_addr_p1;
    logic [31:0]           imem_wdata_p1;

    assign hs        = bus.rx_valid & rdy;
    assign is_sync   = (bus.rx_byte == SYNC_BYTE);
    assign timed     = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHECK);
    // A handshake in the expiry cycle wins, so expiry is only taken on an idle cycle.
    assign expired   = timed && !hs && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign last_lane = (lane_q == 2'd3);
    assign last_word = ((32'(idx_q) + 32'd1) == 32'(len_q));
    assign len_new   = {16'd0, bus.rx_byte, len_q[7:0]};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (hs && is_sync) state_nxt = LEN0;
            LEN0:  if (hs) state_nxt = LEN1;
            LEN1: begin
                if (hs) begin
                    if (len_new > CAPACITY)  state_nxt = ERROR;
                    else if (len_new == 0)   state_nxt = CHECK;
                    else                     state_nxt = DATA;
                end
            end
            DATA:  if (hs && last_lane && last_word) state_nxt = CHECK;
            CHECK: if (hs) state_nxt = (bus.rx_byte == chk_q) ? DONE : ERROR;
            ERROR: if (hs && is_sync) state_nxt = LEN0;
            default: state_nxt = state;
        endcase
        if (expired) state_nxt = ERROR;
    end

    always_comb begin
        rdy  = (state != DONE);
        hold = (state != DONE);
        done = (state == DONE);
        err  = (state == ERROR);
    end

    // Stage p0 -> p1: byte accepted, word assembled, write strobe registered one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q         <= '0;
            chk_q         <= '0;
            idx_q         <= '0;
            lane_q        <= '0;
            shift_q       <= '0;
            timer_q       <= '0;
            imem_we_p1    <= 1'b0;
            imem_addr_p1  <= '0;
            imem_wdata_p1 <= '0;
        end else begin
            imem_we_p1 <= 1'b0;
            if (hs || !timed) timer_q <= '0;
            else              timer_q <= timer_q + 1'b1;

            if (hs) begin
                case (state)
                    IDLE, ERROR: begin
                        if (is_sync) begin
                            chk_q  <= '0;
                            idx_q  <= '0;
                            lane_q <= '0;
                        end
                    end
                    LEN0: begin
                        len_q[7:0] <= bus.rx_byte;
                        chk_q      <= chk_q ^ bus.rx_byte;
                    end
                    LEN1: begin
                        len_q[15:8] <= bus.rx_byte;
                        chk_q       <= chk_q ^ bus.rx_byte;
                    end
                    DATA: begin
                        chk_q <= chk_q ^ bus.rx_byte;
                        if (last_lane) begin
                            imem_we_p1    <= 1'b1;
                            imem_addr_p1  <= idx_q[ADDR_WIDTH-1:0];
                            imem_wdata_p1 <= {bus.rx_byte, shift_q};
                            idx_q         <= idx_q + 1'b1;
                            lane_q        <= '0;
                        end else begin
                            shift_q[{lane_q, 3'b000} +: 8] <= bus.rx_byte;
                            lane_q                         <= lane_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready   = rdy;
    assign bus.core_hold  = hold;
    assign bus.load_done  = done;
    assign bus.load_error = err;
    assign bus.imem_we    = imem_we_p1;
    assign bus.imem_addr  = imem_addr_p1;
    assign bus.imem_wdata = imem_wdata_p1;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream program loader that writes the instruction memory the core fetches from. It is the writer for the instruction-fetch read port.
- Receives a framed program image from a byte source (UART receiver or testbench) and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses.
- Holds the core in reset (core_hold) until a frame with a valid checksum has been fully written.

Parameters:
ADDR_WIDTH, 10, word-address width of the instruction memory; capacity is 2^ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, maximum idle cycles between accepted bytes inside a frame before the frame is aborted

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
rx_valid  input  1  rx_byte holds a valid byte
rx_byte  input  8  incoming stream byte
rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  word to write
core_hold  output  1  keeps the core in reset; core reset = reset | core_hold
load_done  output  1  sticky; program loaded and checksum passed
load_error  output  1  last frame aborted (checksum mismatch, oversize, or timeout)

Behaviour:
- Reset values:
  - state IDLE; imem_we 0; imem_addr 0; imem_wdata 0.
  - core_hold 1; load_done 0; load_error 0; rx_ready 1.
  - Internal counters and checksum are 0.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, N×4 data bytes, CHK.
  - N = {LEN_HI, LEN_LO} is the word count.
  - Each word arrives LSB first.
  - CHK = XOR of LEN_LO, LEN_HI and all data bytes. SYNC_BYTE is excluded.
- States: IDLE, LEN0, LEN1, DATA, CHECK, DONE, ERROR.
- IDLE:
  - A byte equal to SYNC_BYTE moves to LEN0, clears the checksum and sets word index = 0.
  - Other bytes are accepted and discarded.
- LEN0: stores LEN_LO, XORs it into the checksum, moves to LEN1.
- LEN1: stores LEN_HI and XORs it into the checksum, then:
  - if N > 2^ADDR_WIDTH → ERROR;
  - else if N == 0 → CHECK;
  - else → DATA.
- DATA:
  - Each byte is XORed into the checksum and shifted into a byte lane (lane 0 first).
  - On the 4th byte of a word: imem_we = 1 for exactly the next cycle, with imem_addr = word index and imem_wdata = assembled word. Latency is 1 cycle from the 4th handshake.
  - The word index increments after the write.
  - When the word index reaches N → CHECK.
- CHECK:
  - Byte == checksum → DONE.
  - Byte != checksum → ERROR.
- DONE:
  - core_hold 0, load_done 1, rx_ready 0.
  - Terminal until reset.
- ERROR:
  - load_error 1, core_hold 1, rx_ready 1.
  - Non-sync bytes are discarded.
  - SYNC_BYTE clears load_error, resets index and checksum, and goes to LEN0.
  - Words already written stay in memory; a new frame overwrites them from address 0.
- Timeout:
  - In LEN0, LEN1, DATA and CHECK, a counter increments each cycle with no handshake and clears on each handshake.
  - Reaching TIMEOUT_CYCLES → ERROR.
  - A handshake in the same cycle as expiry wins: the byte is processed and the counter cleared.
- imem_we is never asserted outside a word-completion cycle, and is never asserted in DONE or ERROR.
- A byte handshake may occur in the same cycle as an imem_we pulse; the loader sustains one byte per cycle.
- Reset mid-frame: all outputs return to reset values next cycle. Memory contents are not cleared, and no partial word is written.
- Checksum and word-index arithmetic: index is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH is legal and the counter does not wrap.

Test Plan:
1. Valid load: bytes A5 02 00 13 00 00 00 93 00 10 00 92.
   → writes addr0 = 0x00000013 and addr1 = 0x00100093, one cycle after the 7th and 11th bytes.
   → load_done = 1 and core_hold = 0 the cycle after 0x92; rx_ready = 0.
2. Bad checksum: same frame with CHK = 0x00.
   → load_error = 1, core_hold stays 1.
   → Resend the valid frame: load_error clears on A5; load_done = 1 and memory is correct.
3. Empty frame: A5 00 00 00.
   → DONE with zero imem_we pulses.
   → A5 00 00 01 → ERROR.
4. Oversize (ADDR_WIDTH = 10): A5 01 04.
   → ERROR the cycle after LEN_HI; no writes.
   → N = 0x0400 is accepted and fills addresses 0–1023.
5. Timeout (TIMEOUT_CYCLES = 16): A5 01 00 13 00, then silence.
   → ERROR exactly 16 cycles after the last handshake; no write.
   → Repeat with a byte arriving at cycle 16: no error.
6. Robustness: leading garbage 00 FF 5A before a valid frame is ignored and the frame loads.
   → Reset asserted after 2 data bytes gives reset values next cycle, no imem_we; a fresh frame then loads.
